// File: rtl/switch_pkg.sv
// Shared types, defaults and sizing helper for the switch debouncer.
// The long-press option is enabled by defining SWITCH_LONG_PRESS_EN.
package switch_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } debounce_state_t;

  localparam int DEF_N_SWITCHES     = 2;
  localparam int DEF_DEBOUNCE_CNT   = 125;
  localparam int DEF_LONG_PRESS_CNT = 12500;

  // Bits needed to hold values 0..max_count.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One debounce channel: two-flop synchroniser, debounce FSM, edge pulses and
// (with SWITCH_LONG_PRESS_EN) a saturating long-press detector.
//
// state     | meaning
// STABLE_LO | accepted level 0, synchronised input agrees
// PEND_HI   | input went high, counting stable cycles before accepting 1
// STABLE_HI | accepted level 1, synchronised input agrees
// PEND_LO   | input went low, counting stable cycles before accepting 0
module switch_debounce_channel
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
`ifdef SWITCH_LONG_PRESS_EN
  , parameter int LONG_PRESS_CNT = DEF_LONG_PRESS_CNT
`endif
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_switch,
  output logic o_switch,
  output logic o_rise,
  output logic o_fall
`ifdef SWITCH_LONG_PRESS_EN
  , output logic o_long_press
`endif
);

  localparam int             DB_W     = cnt_width(DEBOUNCE_CNT);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CNT - 1);

  logic            sync1;
  logic            sync2;
  debounce_state_t state;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      state    <= STABLE_LO;
      cnt      <= '0;
      o_switch <= 1'b0;
      o_rise   <= 1'b0;
      o_fall   <= 1'b0;
    end else begin
      sync1  <= i_switch;
      sync2  <= sync1;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      unique case (state)
        STABLE_LO: begin
          if (sync2) begin
            state <= PEND_HI;
            cnt   <= '0;
          end
        end
        PEND_HI: begin
          if (!sync2) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= STABLE_HI;
            o_switch <= 1'b1;
            o_rise   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!sync2) begin
            state <= PEND_LO;
            cnt   <= '0;
          end
        end
        PEND_LO: begin
          if (sync2) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= STABLE_LO;
            o_switch <= 1'b0;
            o_fall   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef SWITCH_LONG_PRESS_EN
  localparam int             LP_W    = cnt_width(LONG_PRESS_CNT);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CNT - 1);
  localparam logic [LP_W-1:0] LP_SAT  = LP_W'(LONG_PRESS_CNT);

  logic [LP_W-1:0] long_cnt;

  // Parks at LP_SAT after firing so the pulse cannot repeat until release.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      long_cnt     <= '0;
      o_long_press <= 1'b0;
    end else begin
      o_long_press <= 1'b0;
      if (state == STABLE_HI || state == PEND_LO) begin
        if (long_cnt == LP_LAST) begin
          o_long_press <= 1'b1;
          long_cnt     <= LP_SAT;
        end else if (long_cnt < LP_LAST) begin
          long_cnt <= long_cnt + 1'b1;
        end
      end else begin
        long_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: one independent channel per switch input.
// Define SWITCH_LONG_PRESS_EN to add the o_long_press output.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int N_SWITCHES     = DEF_N_SWITCHES,
  parameter int DEBOUNCE_CNT   = DEF_DEBOUNCE_CNT,
  parameter int LONG_PRESS_CNT = DEF_LONG_PRESS_CNT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [N_SWITCHES-1:0] i_switch,
  output logic [N_SWITCHES-1:0] o_switch,
  output logic [N_SWITCHES-1:0] o_rise,
  output logic [N_SWITCHES-1:0] o_fall
`ifdef SWITCH_LONG_PRESS_EN
  , output logic [N_SWITCHES-1:0] o_long_press
`endif
);

  localparam bit CFG_OK = (N_SWITCHES >= 1) && (DEBOUNCE_CNT >= 1) && (LONG_PRESS_CNT >= 1);

  // An out-of-range configuration builds no channels and holds outputs low.
  generate
    if (CFG_OK) begin : g_cfg
      for (genvar k = 0; k < N_SWITCHES; k++) begin : g_ch
        switch_debounce_channel #(
          .DEBOUNCE_CNT   (DEBOUNCE_CNT)
`ifdef SWITCH_LONG_PRESS_EN
          , .LONG_PRESS_CNT (LONG_PRESS_CNT)
`endif
        ) u_ch (
          .i_clock  (i_clock),
          .i_reset  (i_reset),
          .i_switch (i_switch[k]),
          .o_switch (o_switch[k]),
          .o_rise   (o_rise[k]),
          .o_fall   (o_fall[k])
`ifdef SWITCH_LONG_PRESS_EN
          , .o_long_press (o_long_press[k])
`endif
        );
      end
    end else begin : g_bad_cfg
      assign o_switch = '0;
      assign o_rise   = '0;
      assign o_fall   = '0;
`ifdef SWITCH_LONG_PRESS_EN
      assign o_long_press = '0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed scenarios then random
// bouncing input, compared against a mismatch-run reference model.
module tb_switch_debouncer;

  localparam int N  = 2;
  localparam int DB = 4;
  localparam int LP = 10;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic [N-1:0] i_switch;
  logic [N-1:0] o_switch;
  logic [N-1:0] o_rise;
  logic [N-1:0] o_fall;
`ifdef SWITCH_LONG_PRESS_EN
  logic [N-1:0] o_long_press;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: raw samples pass a 2-deep delay line; the accepted level
  // flips once the delayed input has disagreed with it for DB+1 edges running.
  logic [N-1:0] m_dly1, m_dly2, m_level, m_rise, m_fall, m_lp;
  int           m_run [N];
  int           m_hi  [N];

  always #5 i_clock = ~i_clock;

  switch_debouncer #(
    .N_SWITCHES     (N),
    .DEBOUNCE_CNT   (DB),
    .LONG_PRESS_CNT (LP)
  ) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_switch (i_switch),
    .o_switch (o_switch),
    .o_rise   (o_rise),
    .o_fall   (o_fall)
`ifdef SWITCH_LONG_PRESS_EN
    , .o_long_press (o_long_press)
`endif
  );

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [N-1:0] raw);
    if (rst) begin
      m_dly1 = '0; m_dly2 = '0; m_level = '0;
      m_rise = '0; m_fall = '0; m_lp = '0;
      for (int k = 0; k < N; k++) begin
        m_run[k] = 0;
        m_hi[k]  = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        m_lp[k]   = 1'b0;
        if (m_level[k]) begin
          m_hi[k]++;
          if (m_hi[k] == LP) m_lp[k] = 1'b1;
        end else begin
          m_hi[k] = 0;
        end
        if (m_dly2[k] != m_level[k]) m_run[k]++;
        else m_run[k] = 0;
        if (m_run[k] == DB + 1) begin
          m_level[k] = ~m_level[k];
          m_rise[k]  = m_level[k];
          m_fall[k]  = ~m_level[k];
          m_run[k]   = 0;
        end
        m_dly2[k] = m_dly1[k];
        m_dly1[k] = raw[k];
      end
    end
  endtask

  task automatic step(input logic rst, input logic [N-1:0] raw);
    i_reset  = rst;
    i_switch = raw;
    @(posedge i_clock);
    model_edge(rst, raw);
    #1;
    check("o_switch", o_switch, m_level);
    check("o_rise", o_rise, m_rise);
    check("o_fall", o_fall, m_fall);
    check("rise_and_fall", o_rise & o_fall, '0);
`ifdef SWITCH_LONG_PRESS_EN
    check("o_long_press", o_long_press, m_lp);
`endif
  endtask

  initial begin
    int           rise_edge;
    int           fall_edge;
    int           lp_count;
    int           lp_edge;
    logic [N-1:0] seen_fall;
    logic [N-1:0] raw;
    logic         rst;
    int           len;

    m_dly1 = '0; m_dly2 = '0; m_level = '0;
    m_rise = '0; m_fall = '0; m_lp = '0;
    for (int k = 0; k < N; k++) begin
      m_run[k] = 0;
      m_hi[k]  = 0;
    end

    // Reset, then idle low.
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    check("reset_switch", o_switch, 2'b00);
    check("reset_rise", o_rise, 2'b00);
    repeat (20) step(1'b0, 2'b00);
    check("idle_switch", o_switch, 2'b00);

    // Ch0 rises; accepted exactly at edge DB+3.
    for (int e = 1; e <= 9; e++) begin
      step(1'b0, 2'b01);
      if (e == 6) check("ch0_before_accept", o_switch, 2'b00);
      if (e == 7) begin
        check("ch0_rise_edge7", o_rise, 2'b01);
        check("ch0_switch_edge7", o_switch, 2'b01);
      end
      if (e == 8) check("ch0_rise_one_cycle", o_rise, 2'b00);
    end

    // Ch0 bounces every cycle and ends high: no fall.
    seen_fall = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i % 2 == 0) ? 2'b01 : 2'b00);
      seen_fall |= o_fall;
    end
    repeat (10) begin
      step(1'b0, 2'b01);
      seen_fall |= o_fall;
    end
    check("bounce_no_fall", seen_fall, 2'b00);
    check("bounce_switch_held", o_switch, 2'b01);

    repeat (10) step(1'b0, 2'b00);
    check("ch0_released", o_switch, 2'b00);

    // Both channels rise together.
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 2'b11);
      if (e == 7) check("both_rise_edge7", o_rise, 2'b11);
    end
    repeat (10) step(1'b0, 2'b00);

    // Ch1 long hold, then release.
    rise_edge = -1;
    lp_count  = 0;
    lp_edge   = -1;
    for (int e = 1; e <= 30; e++) begin
      step(1'b0, 2'b10);
      if (o_rise[1]) rise_edge = e;
`ifdef SWITCH_LONG_PRESS_EN
      if (o_long_press[1]) begin
        lp_count++;
        lp_edge = e;
      end
`endif
    end
    total++;
    assert (rise_edge == 7)
    else begin
      bad++;
      $error("FAIL ch1_rise_edge observed=%0d expected=7", rise_edge);
    end
`ifdef SWITCH_LONG_PRESS_EN
    total++;
    assert (lp_count == 1)
    else begin
      bad++;
      $error("FAIL ch1_long_press_count observed=%0d expected=1", lp_count);
    end
    total++;
    assert (lp_edge - rise_edge == LP)
    else begin
      bad++;
      $error("FAIL ch1_long_press_delay observed=%0d expected=%0d", lp_edge - rise_edge, LP);
    end
`endif
    fall_edge = -1;
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 2'b00);
      if (o_fall[1]) fall_edge = e;
    end
    total++;
    assert (fall_edge == 7)
    else begin
      bad++;
      $error("FAIL ch1_fall_edge observed=%0d expected=7", fall_edge);
    end

    // Reset while ch0 is pending high with count 2, raw still high.
    repeat (5) step(1'b0, 2'b01);
    step(1'b1, 2'b01);
    check("reset_mid_switch", o_switch, 2'b00);
    check("reset_mid_rise", o_rise, 2'b00);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 2'b01);
      if (e == 6) check("rearm_before", o_rise, 2'b00);
      if (e == 7) check("rearm_rise_edge7", o_rise, 2'b01);
    end

    // Random segments: short glitches, long holds, occasional reset.
    for (int s = 0; s < 200; s++) begin
      raw = N'($urandom);
      len = $urandom_range(1, 14);
      rst = ($urandom_range(0, 29) == 0);
      for (int c = 0; c < len; c++) step((c == 0) ? rst : 1'b0, raw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Input-side companion to the LED drive logic: synchronises and debounces raw mechanical switch/button inputs and presents clean levels plus single-cycle edge pulses to downstream logic (blinker rate selection, enable). One instance serves `N_SWITCHES` independent channels in the `i_clock` domain. An optional long-press detector is compiled in per channel.

## Interface
- `N_SWITCHES`, default 2: number of independent channels, ≥1.
- `DEBOUNCE_CNT`, default 125: consecutive stable synchronised cycles required to accept a new level, ≥1.
- `LONG_PRESS_CNT`, default 12500: cycles `o_switch` must stay high before `o_long_press` fires, ≥1. Used only with `SWITCH_LONG_PRESS_EN`.
- `i_clock`  in  1  system clock.
- `i_reset`  in  1  reset, synchronous, active-high; clock `i_clock`.
- `i_switch`  in  N_SWITCHES  raw asynchronous switch levels.
- `o_switch`  out  N_SWITCHES  debounced level, registered.
- `o_rise`  out  N_SWITCHES  one-cycle pulse when `o_switch[k]` goes 0→1.
- `o_fall`  out  N_SWITCHES  one-cycle pulse when `o_switch[k]` goes 1→0.
- `o_long_press`  out  N_SWITCHES  one-cycle pulse on long press. Present only with the macro.

## Operation
- Each channel has a two-flop synchroniser (`sync1`, `sync2`) on `i_switch[k]`. Reset value is 0.
- Per-channel FSM states: `STABLE_LO`, `PEND_HI`, `STABLE_HI`, `PEND_LO`.
  - `STABLE_LO`: `sync2`=1 → `PEND_HI` and count←0.
  - `PEND_HI`: `sync2`=0 → `STABLE_LO` (bounce abort, count←0, no pulse).
    - Otherwise, if count==`DEBOUNCE_CNT`-1 → `STABLE_HI`, `o_switch`←1, `o_rise`←1.
    - Otherwise count←count+1.
  - `STABLE_HI` and `PEND_LO` are the mirror image. Accepting the new level sets `o_switch`←0 and `o_fall`←1.
- Debounce counter width is `$clog2(DEBOUNCE_CNT+1)`. It never exceeds `DEBOUNCE_CNT`-1 and never wraps.
- `o_rise` and `o_fall` are high for exactly one cycle and are never both high on the same channel. Each goes high in the same cycle that `o_switch` takes its new value.
- Channels are fully independent. Simultaneous events on different channels are each reported in the same cycle.
- Reset while an operation is in progress:
  - The next edge forces every channel to `STABLE_LO`, clears all counters, and drives all outputs to 0.
  - A switch held high through reset is re-debounced afterwards and produces a fresh `o_rise`.

## Timing
- Reset values: `o_switch`=0, `o_rise`=0, `o_fall`=0, `o_long_press`=0, all FSMs in `STABLE_LO`.
- Latency assumes the raw level is stable. Edge 1 is the first rising edge that samples the new level into `sync1`.
  - `sync2` updates at edge 2.
  - The FSM enters `PEND_*` at edge 3.
  - `o_switch` and the matching edge pulse update at edge `DEBOUNCE_CNT`+3.
- A glitch shorter than `DEBOUNCE_CNT`+1 synchronised cycles produces no output change.
- All outputs are registered. There is no combinational path from `i_switch` to any output.

## Configuration
- Macro: `SWITCH_LONG_PRESS_EN`.
- Defined:
  - Each channel adds a long counter of width `$clog2(LONG_PRESS_CNT+1)`, cleared whenever the FSM is not in `STABLE_HI` or `PEND_LO`.
  - The counter increments every cycle in those states. When it equals `LONG_PRESS_CNT`-1, `o_long_press[k]` pulses for one cycle.
  - The counter then saturates, so there is no repeat until release.
  - A bounce back to `STABLE_HI` from `PEND_LO` does not clear the counter.
- Undefined: the long counter, its logic and the `o_long_press` port are absent. All other behaviour is identical.

## Structure
- Package `switch_pkg` holds:
  - typedef enum `debounce_state_t` with the four states;
  - constant function for counter widths;
  - default parameter values.
- Sub-module `switch_debounce_channel` contains one synchroniser, FSM, counters and pulse generation.
- The top level instantiates one `switch_debounce_channel` per channel with a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CNT`=4, `LONG_PRESS_CNT`=10, `N_SWITCHES`=2.
- Reset, then `i_switch`=2'b00 for 20 cycles → all outputs 0, no pulses.
- Raw ch0 0→1 held → `o_switch[0]`=1 and `o_rise[0]`=1 for exactly one cycle at edge 7. `o_fall` stays 0.
- Ch0 high, then raw toggles 1,0,1,0 each cycle for 8 cycles and ends at 1 → no `o_fall`, `o_switch[0]` stays 1.
- Both channels rise on the same edge → `o_rise`=2'b11 in one cycle at edge 7.
- Ch1 held high 30 cycles with macro defined → exactly one `o_long_press[1]` pulse, 10 cycles after `o_switch[1]` rose. Release gives `o_fall[1]` at edge 7 after the raw fall.
- `i_reset` asserted while ch0 is in `PEND_HI` (count=2) with raw still high → outputs 0 the next cycle. After release, `o_rise[0]` comes 7 edges later.
